// File: rtl/k2_pkg.sv
// Shared types and constants for the K2 core sequencer slice.
package k2_pkg;

  localparam int PC_WIDTH    = 4;
  localparam int INSTR_WIDTH = 8;

  localparam logic [PC_WIDTH-1:0] PC_RESET = '0;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    MEM   = 2'd2,
    HALT  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/k2_flag_reg.sv
// Zero/carry flag register with write enable. It is kept standalone so a
// later interrupt save/restore path can reuse it.
module k2_flag_reg (
  input  logic clk,
  input  logic rst_n,
  input  logic we_i,
  input  logic zf_i,
  input  logic cf_i,
  output logic zf_o,
  output logic cf_o
);

  logic zf_q, zf_d;
  logic cf_q, cf_d;

  always_comb begin
    zf_d = zf_q;
    cf_d = cf_q;
    if (we_i) begin
      zf_d = zf_i;
      cf_d = cf_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zf_q <= 1'b0;
      cf_q <= 1'b0;
    end else begin
      zf_q <= zf_d;
      cf_q <= cf_d;
    end
  end

  assign zf_o = zf_q;
  assign cf_o = cf_q;

endmodule

// File: rtl/k2_pc_sequencer.sv
// K2 program counter and phase sequencer: FETCH/EXEC/MEM/HALT control,
// instruction latch and flag register, all outputs registered.
module k2_pc_sequencer
  import k2_pkg::*;
#(
  parameter int PC_WIDTH    = k2_pkg::PC_WIDTH,
  parameter int INSTR_WIDTH = k2_pkg::INSTR_WIDTH,
  parameter int IMM_WIDTH   = k2_pkg::PC_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run_i,
  input  logic [INSTR_WIDTH-1:0] instr_i,
  input  logic [IMM_WIDTH-1:0]   imm_i,
  input  logic                   mem_op_i,
  input  logic                   JCF,
  input  logic                   alu_zf_i,
  input  logic                   alu_cf_i,
  input  logic                   flag_we_i,
  output logic [PC_WIDTH-1:0]    pc_o,
  output logic [INSTR_WIDTH-1:0] ir_o,
  output logic                   S_reg,
  output logic                   ZF,
  output logic                   CF,
  output logic                   halted_o
);

  seq_state_t             state_q;
  logic [PC_WIDTH-1:0]    pc_q;
  logic [INSTR_WIDTH-1:0] ir_q;
  logic                   s_q;
  logic                   halted_q;
  logic                   flag_we;

  // Flags only move in a live EXEC cycle; HALT and frozen cycles leave them alone.
  assign flag_we = run_i && (state_q == EXEC) && flag_we_i;

  k2_flag_reg u_flags (
    .clk   (clk),
    .rst_n (rst_n),
    .we_i  (flag_we),
    .zf_i  (alu_zf_i),
    .cf_i  (alu_cf_i),
    .zf_o  (ZF),
    .cf_o  (CF)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FETCH;
      pc_q     <= PC_WIDTH'(PC_RESET);
      ir_q     <= '0;
      s_q      <= 1'b0;
      halted_q <= 1'b0;
    end else if (run_i) begin
      case (state_q)
        FETCH: begin
          ir_q    <= instr_i;
          state_q <= EXEC;
        end
        EXEC: begin
          if (mem_op_i) begin
            s_q     <= 1'b1;
            state_q <= MEM;
          end else if (JCF) begin
            // A jump onto itself is the program's halt idiom.
            if (PC_WIDTH'(imm_i) == pc_q) begin
              halted_q <= 1'b1;
              state_q  <= HALT;
            end else begin
              pc_q    <= PC_WIDTH'(imm_i);
              state_q <= FETCH;
            end
          end else begin
            pc_q    <= pc_q + PC_WIDTH'(1);
            state_q <= FETCH;
          end
        end
        MEM: begin
          pc_q    <= pc_q + PC_WIDTH'(1);
          s_q     <= 1'b0;
          state_q <= FETCH;
        end
        default: begin
          state_q <= HALT;
        end
      endcase
    end
  end

  assign pc_o     = pc_q;
  assign ir_o     = ir_q;
  assign S_reg    = s_q;
  assign halted_o = halted_q;

endmodule

// File: tb/tb_k2_pc_sequencer.sv
// Self-checking bench for k2_pc_sequencer: instruction-level reference model
// compared every cycle, plus hand-computed literal expectations.
module tb_k2_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       run_i = 1'b0;
  logic [7:0] instr_i = '0;
  logic [3:0] imm_i = '0;
  logic       mem_op_i = 1'b0;
  logic       JCF = 1'b0;
  logic       alu_zf_i = 1'b0;
  logic       alu_cf_i = 1'b0;
  logic       flag_we_i = 1'b0;
  logic [3:0] pc_o;
  logic [7:0] ir_o;
  logic       S_reg, ZF, CF, halted_o;

  int checks = 0;
  int passed = 0;
  bit cmp_en = 1'b0;

  k2_pc_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run_i     (run_i),
    .instr_i   (instr_i),
    .imm_i     (imm_i),
    .mem_op_i  (mem_op_i),
    .JCF       (JCF),
    .alu_zf_i  (alu_zf_i),
    .alu_cf_i  (alu_cf_i),
    .flag_we_i (flag_we_i),
    .pc_o      (pc_o),
    .ir_o      (ir_o),
    .S_reg     (S_reg),
    .ZF        (ZF),
    .CF        (CF),
    .halted_o  (halted_o)
  );

  always #5 clk = ~clk;

  // Reference model: "step" counts the cycle within the current instruction
  // (0 = fetch, 1 = execute, 2 = memory access); stopped is the halt latch.
  int m_pc = 0, m_ir = 0, m_step = 0, m_zf = 0, m_cf = 0;
  bit m_stopped = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 0; m_ir = 0; m_step = 0; m_zf = 0; m_cf = 0; m_stopped = 1'b0;
    end else if (!m_stopped && run_i) begin
      if (m_step == 0) begin
        m_ir = int'(instr_i);
        m_step = 1;
      end else if (m_step == 1) begin
        if (flag_we_i) begin
          m_zf = int'(alu_zf_i);
          m_cf = int'(alu_cf_i);
        end
        if (mem_op_i) m_step = 2;
        else if (JCF && int'(imm_i) == m_pc) m_stopped = 1'b1;
        else begin
          m_pc = JCF ? int'(imm_i) : (m_pc + 1) % 16;
          m_step = 0;
        end
      end else begin
        m_pc = (m_pc + 1) % 16;
        m_step = 0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      checks++;
      if (int'(pc_o) == m_pc && int'(ir_o) == m_ir && S_reg == (m_step == 2) &&
          int'(ZF) == m_zf && int'(CF) == m_cf && halted_o == m_stopped)
        passed++;
      else
        $display("FAIL model t=%0t: got pc=%0d ir=%0h S=%0b ZF=%0b CF=%0b halt=%0b expected pc=%0d ir=%0h S=%0b ZF=%0d CF=%0d halt=%0b",
                 $time, pc_o, ir_o, S_reg, ZF, CF, halted_o,
                 m_pc, m_ir, (m_step == 2), m_zf, m_cf, m_stopped);
    end
  end

  // Drive one cycle's inputs, let the rising edge consume them, settle 1 ns.
  task automatic cyc(input logic run, input logic [7:0] ins, input logic mem,
                     input logic jcf, input logic [3:0] imm, input logic fwe,
                     input logic zf, input logic cf);
    run_i = run; instr_i = ins; mem_op_i = mem; JCF = jcf; imm_i = imm;
    flag_we_i = fwe; alu_zf_i = zf; alu_cf_i = cf;
    @(posedge clk); #1;
  endtask

  // Plain instruction: fetch then execute with no jump, memory or flag write.
  task automatic plain(input logic [7:0] ins);
    cyc(1'b1, ins, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic jump(input logic [3:0] tgt);
    cyc(1'b1, 8'hC0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h00, 1'b0, 1'b1, tgt, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc", int'(pc_o), 0);
    chk("reset_halt", int'(halted_o), 0);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // Sequential flow 0 -> 4, each advance two cycles apart.
    plain(8'hA0);
    chk("seq_pc1", int'(pc_o), 1);
    cyc(1'b1, 8'hA1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("seq_fetch_hold", int'(pc_o), 1);
    chk("seq_ir", int'(ir_o), 8'hA1);
    cyc(1'b1, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    plain(8'hA2);
    // Fourth instruction also writes ZF=1 CF=1 so the reset check means something.
    cyc(1'b1, 8'hA3, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h00, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
    chk("seq_pc4", int'(pc_o), 4);
    chk("seq_flags", int'({ZF, CF}), 3);
    plain(8'hA4);
    chk("seq_pc5", int'(pc_o), 5);

    // Reset asserted in the EXEC cycle at pc=5: outputs clear immediately.
    cyc(1'b1, 8'hA5, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    run_i = 1'b1; flag_we_i = 1'b1; JCF = 1'b1; imm_i = 4'd12;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pc", int'(pc_o), 0);
    chk("arst_ir", int'(ir_o), 0);
    chk("arst_S", int'(S_reg), 0);
    chk("arst_flags", int'({ZF, CF}), 0);
    chk("arst_halt", int'(halted_o), 0);
    cyc(1'b1, 8'h55, 1'b0, 1'b1, 4'd12, 1'b1, 1'b1, 1'b1);
    rst_n = 1'b1;
    plain(8'hB0);
    chk("post_rst_pc", int'(pc_o), 1);
    plain(8'hB1);
    plain(8'hB2);

    // Jump at pc=3 to 9, with a flag write in the same cycle.
    cyc(1'b1, 8'hC3, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h00, 1'b0, 1'b1, 4'd9, 1'b1, 1'b0, 1'b1);
    chk("jump_pc9", int'(pc_o), 9);
    chk("jump_flags", int'({ZF, CF}), 1);

    // Memory instruction at pc=6; freeze inside MEM, JCF high throughout.
    jump(4'd6);
    cyc(1'b1, 8'hD6, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h00, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("mem_S", int'(S_reg), 1);
    chk("mem_pc", int'(pc_o), 6);
    for (int i = 0; i < 5; i++)
      cyc(1'b0, 8'hEE, 1'b0, 1'b1, 4'd2, 1'b1, 1'b1, 1'b0);
    chk("frz_S", int'(S_reg), 1);
    chk("frz_pc", int'(pc_o), 6);
    chk("frz_flags", int'({ZF, CF}), 1);
    cyc(1'b1, 8'hEE, 1'b0, 1'b1, 4'd2, 1'b1, 1'b1, 1'b0);
    chk("mem_done_pc", int'(pc_o), 7);
    chk("mem_done_S", int'(S_reg), 0);
    chk("mem_flags_kept", int'({ZF, CF}), 1);

    // Freeze in EXEC, then wrap 15 -> 0 with a flag write.
    jump(4'd15);
    cyc(1'b1, 8'hF5, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 8'h11, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    chk("frz_exec_pc", int'(pc_o), 15);
    chk("frz_exec_ir", int'(ir_o), 8'hF5);
    cyc(1'b1, 8'h00, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    chk("wrap_pc", int'(pc_o), 0);
    chk("wrap_flags", int'({ZF, CF}), 2);

    // Self-jump at 9 halts; nothing but reset may move it afterwards.
    jump(4'd9);
    cyc(1'b1, 8'h99, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h00, 1'b0, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
    chk("halt_flag", int'(halted_o), 1);
    for (int i = 0; i < 12; i++)
      cyc(logic'(i % 2), 8'h77, logic'(i % 3 == 0), 1'b1, 4'(i), 1'b1, 1'b1, 1'b1);
    chk("halt_pc", int'(pc_o), 9);
    chk("halt_ir", int'(ir_o), 8'h99);
    chk("halt_flags", int'({ZF, CF}), 2);
    chk("halt_stays", int'(halted_o), 1);

    rst_n = 1'b0;
    #1;
    chk("halt_reset", int'({halted_o, pc_o}), 0);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/k2_pc_sequencer.md
Name: k2_pc_sequencer

Overview:
- Program-counter and phase sequencer for the K2 core. It sits directly upstream and downstream of the jump/condition-flag logic.
- Feeds that logic the registered flags `ZF`/`CF` and the phase bit `S_reg`.
- Consumes its `JCF` (jump-taken) output to load the PC with the branch target.
- Also owns the `run`/`halt` control and the instruction-register latch.

Parameters:
- PC_WIDTH, 4, program counter / instruction address width (16-entry instruction memory).
- INSTR_WIDTH, 8, instruction word width.
- IMM_WIDTH, 4, width of the branch-target field; must equal PC_WIDTH.

Ports:
- clk  in  1  core clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run_i  in  1  level; 1 = execute, 0 = freeze PC/phase/flags.
- instr_i  in  INSTR_WIDTH  word read from instruction memory at `pc_o`.
- imm_i  in  IMM_WIDTH  branch target decoded from `ir_o`.
- mem_op_i  in  1  decoder: current instruction needs the second (memory) phase.
- JCF  in  1  jump-taken from the condition logic.
- alu_zf_i  in  1  ALU zero result.
- alu_cf_i  in  1  ALU carry result.
- flag_we_i  in  1  decoder: current instruction updates flags.
- pc_o  out  PC_WIDTH  current instruction address.
- ir_o  out  INSTR_WIDTH  latched instruction.
- S_reg  out  1  phase bit: 0 = execute phase, 1 = memory phase.
- ZF  out  1  registered zero flag.
- CF  out  1  registered carry flag.
- halted_o  out  1  core halted (self-jump detected).

Behaviour:
- **Reset (async, rst_n=0):**
  - State = FETCH, `pc_o`=0, `ir_o`=0, `S_reg`=0, `ZF`=0, `CF`=0, `halted_o`=0.
  - Reset asserted mid-instruction abandons it; no partial flag/PC update survives.
- **FSM states:** FETCH, EXEC, MEM, HALT. `S_reg`=1 only in MEM.
- **run_i=0:** every register holds in any state, including a pending MEM. On return to 1, resume exactly where frozen.
- **FETCH** (run_i=1):
  - `ir_o` <= `instr_i`; go EXEC.
  - PC unchanged.
  - 1-cycle instruction-memory latency is assumed: `instr_i` is valid the cycle `pc_o` is stable.
- **EXEC** (run_i=1), decoder outputs derive from `ir_o`:
  - If `flag_we_i`: `ZF`<=`alu_zf_i`, `CF`<=`alu_cf_i`.
  - If `mem_op_i`: go MEM, PC held.
  - Else if `JCF`:
    - If `imm_i`==`pc_o`, go HALT with `halted_o`<=1 and PC unchanged.
    - Otherwise `pc_o`<=`imm_i` and go FETCH.
  - Else `pc_o`<=`pc_o`+1 (mod 2^PC_WIDTH, 15 wraps to 0); go FETCH.
  - `JCF` sampled in EXEC uses flags *before* this cycle's update (registered `ZF`/`CF`). Flag write and jump in the same cycle are both honoured.
- **MEM** (run_i=1):
  - Flags unchanged; `JCF` ignored (condition logic gates it with `S_reg`).
  - `pc_o`<=`pc_o`+1 with wrap; `S_reg`<=0; go FETCH.
- **HALT:** all outputs hold; only reset exits. `run_i` has no effect.
- **Instruction timing:** CPI = 2 for ALU/jump instructions, 3 for memory instructions.
- **Outputs:** all are registered; no combinational path from any input to any output.

Decomposition:
- Shared package `k2_pkg`: state enum `seq_state_t` {FETCH, EXEC, MEM, HALT}, PC_WIDTH/INSTR_WIDTH constants, reset PC constant `PC_RESET`=0.
- One natural sub-module: `k2_flag_reg`. It holds the ZF/CF register with write-enable and async active-low reset, and is reused by a future interrupt save/restore path.
- The FSM and PC stay in the top module.

Test Plan:
- **Reset/startup:** assert rst_n=0 mid-EXEC with pc=5 → outputs immediately pc=0, S_reg=0, ZF=CF=0, halted_o=0. Release → FETCH at pc=0.
- **Sequential flow:** 4 non-jump, non-mem instructions with JCF=0 → pc 0→1→2→3→4, each advance 2 cycles after the previous.
- **Wrap and flags:** pc=15, flag_we=1, alu_zf=1, alu_cf=0, JCF=0 in EXEC → pc=0, ZF=1, CF=0 next cycle.
- **Jump/halt:** at pc=3, JCF=1, imm=9 → pc=9. Then at pc=9, JCF=1, imm=9 → halted_o=1, pc stays 9 for 10+ cycles with run_i toggling.
- **Memory phase:** at pc=6, mem_op=1 in EXEC → next cycle S_reg=1, pc=6. JCF=1 forced during MEM is ignored → pc=7, S_reg=0.
- **Freeze:** run_i=0 for 5 cycles while in MEM → S_reg stays 1, pc and flags unchanged. run_i=1 → completes to pc+1.
